// File: rtl/button_conditioner.sv
// Pushbutton front end: 2-FF synchroniser, debounce FSM, press/release/long ticks.
// Define AUTO_REPEAT_EN to repeat the press tick while the button is held past the long time.
module button_conditioner #(
  parameter int unsigned CLK_FREQ    = 100_000_000,
  parameter int unsigned DEBOUNCE_MS = 10,
  parameter int unsigned LONG_MS     = 1000,
  parameter int unsigned REPEAT_MS   = 200
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic button_in_i,
  output logic button_out_o,
  output logic release_tick_o,
  output logic level_o,
  output logic long_tick_o
);

  localparam int unsigned DbCyc   = CLK_FREQ / 1000 * DEBOUNCE_MS;
  localparam int unsigned LongCyc = CLK_FREQ / 1000 * LONG_MS;
  localparam int unsigned RepCyc  = CLK_FREQ / 1000 * REPEAT_MS;
  localparam int unsigned CntW    = $clog2(DbCyc + 1);
  localparam int unsigned HoldW   = $clog2(LongCyc + 1);

  localparam logic [CntW-1:0]  DbMax   = CntW'(DbCyc);
  localparam logic [CntW-1:0]  CntOne  = CntW'(1);
  localparam logic [HoldW-1:0] LongMax = HoldW'(LongCyc);
  localparam logic [HoldW-1:0] LongPre = HoldW'(LongCyc - 1);
  localparam logic [HoldW-1:0] HoldOne = HoldW'(1);

  // Zero-length timings would make the tick rules meaningless.
  if (DbCyc == 0) begin : g_bad_db
    $error("button_conditioner: debounce time rounds to zero cycles");
  end
  if (LongCyc == 0) begin : g_bad_long
    $error("button_conditioner: long-press time rounds to zero cycles");
  end
  if (RepCyc == 0) begin : g_bad_rep
    $error("button_conditioner: repeat period rounds to zero cycles");
  end

  typedef enum logic [1:0] {
    StIdle,
    StPressWait,
    StPressed,
    StReleaseWait
  } state_e;

  state_e           state_q;
  logic [1:0]       sync_q;
  logic [CntW-1:0]  cnt_q;
  logic [HoldW-1:0] hold_q;
  logic             button_out_q;
  logic             release_q;
  logic             level_q;
  logic             long_q;
  logic             s;

`ifdef AUTO_REPEAT_EN
  localparam int unsigned RepW = $clog2(RepCyc + 1);
  localparam logic [RepW-1:0] RepPre = RepW'(RepCyc - 1);
  localparam logic [RepW-1:0] RepOne = RepW'(1);
  logic [RepW-1:0] rep_q;
`endif

  assign s = sync_q[1];

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      sync_q       <= '0;
      state_q      <= StIdle;
      cnt_q        <= '0;
      hold_q       <= '0;
      button_out_q <= 1'b0;
      release_q    <= 1'b0;
      level_q      <= 1'b0;
      long_q       <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rep_q        <= '0;
`endif
    end else begin
      sync_q       <= {sync_q[0], button_in_i};
      button_out_q <= 1'b0;
      release_q    <= 1'b0;
      long_q       <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (s) begin
            state_q <= StPressWait;
            cnt_q   <= CntOne;
          end
        end
        StPressWait: begin
          if (!s) begin
            state_q <= StIdle;
          end else if (cnt_q == DbMax) begin
            state_q      <= StPressed;
            hold_q       <= '0;
            button_out_q <= 1'b1;
            level_q      <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StPressed: begin
          // hold saturates; once saturated the repeat counter takes over
          if (hold_q != LongMax) begin
            hold_q <= hold_q + HoldOne;
            if (hold_q == LongPre) long_q <= 1'b1;
          end
`ifdef AUTO_REPEAT_EN
          else if (rep_q == RepPre) begin
            rep_q        <= '0;
            button_out_q <= 1'b1;
          end else begin
            rep_q <= rep_q + RepOne;
          end
`endif
          if (!s) begin
            state_q <= StReleaseWait;
            cnt_q   <= CntOne;
          end
        end
        StReleaseWait: begin
          // hold and repeat are kept, so contact bounce cannot re-fire ticks
          if (s) begin
            state_q <= StPressed;
          end else if (cnt_q == DbMax) begin
            state_q   <= StIdle;
            level_q   <= 1'b0;
            release_q <= 1'b1;
`ifdef AUTO_REPEAT_EN
            rep_q     <= '0;
`endif
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign button_out_o   = button_out_q;
  assign release_tick_o = release_q;
  assign level_o        = level_q;
  assign long_tick_o    = long_q;

  a_press_single: assert property (@(posedge clk_i) disable iff (!reset_ni)
    button_out_q |=> !button_out_q);
  a_release_single: assert property (@(posedge clk_i) disable iff (!reset_ni)
    release_q |=> !release_q);
  a_long_single: assert property (@(posedge clk_i) disable iff (!reset_ni)
    long_q |=> !long_q);
`ifndef AUTO_REPEAT_EN
  a_long_press_excl: assert property (@(posedge clk_i) disable iff (!reset_ni)
    !(long_q && button_out_q));
`endif

endmodule
